// File: rtl/oam_dma_controller.sv
// Sprite OAM DMA sequencer ($4014).
// A CPU write of page P halts the CPU and copies $P00..$P(XFER_LEN-1) from
// the CPU bus into OAM through the PPU $2004 write path, one byte per
// get/put CPU-cycle pair. All transfer work advances only on cpu_ce.
// Optional debug ports are built when OAM_DMA_DEBUG_EN is defined.
// XFER_LEN must be a power of two, no greater than 256.
module oam_dma_controller #(
    parameter int PAGE_W   = 8,
    parameter int XFER_LEN = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_ce,
    input  logic              dma_wr,
    input  logic [PAGE_W-1:0] dma_page,
    input  logic [7:0]        mem_rdata,
    output logic              cpu_halt,
    output logic [15:0]       mem_addr,
    output logic              mem_rd,
    output logic              oam_wr,
    output logic [7:0]        oam_data,
    output logic              busy,
    output logic              done
`ifdef OAM_DMA_DEBUG_EN
    ,
    output logic [15:0]       dbg_count,
    output logic [7:0]        dbg_last_page
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t            state_q, state_d;
    logic              cyc_odd_q;
    logic [7:0]        idx_q, idx_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic [7:0]        data_q, data_d;
    logic              accept;

    // State register; cyc_odd tracks get/put parity on every CPU cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cyc_odd_q <= 1'b0;
            idx_q     <= 8'd0;
            page_q    <= '0;
            data_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            cyc_odd_q <= cpu_ce ? ~cyc_odd_q : cyc_odd_q;
            idx_q     <= idx_d;
            page_q    <= page_d;
            data_q    <= data_d;
        end
    end

    // Next-state and strobes; nothing moves on clks without cpu_ce.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        data_d  = data_q;
        oam_wr  = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        if (cpu_ce) begin
            case (state_q)
                IDLE: begin
                    if (dma_wr) begin
                        accept  = 1'b1;
                        page_d  = dma_page;
                        idx_d   = 8'd0;
                        state_d = HALT;
                    end
                end
                // Odd HALT means the next cycle is already a get cycle.
                HALT:  state_d = cyc_odd_q ? READ : ALIGN;
                ALIGN: state_d = READ;
                READ: begin
                    data_d  = mem_rdata;
                    state_d = WRITE;
                end
                WRITE: begin
                    // Reset on this clk suppresses the strobe: no write once reset is seen.
                    oam_wr = ~reset;
                    if (idx_q == LAST_IDX) begin
                        done    = ~reset;
                        idx_d   = 8'd0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = READ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign cpu_halt = busy;
    assign mem_rd   = (state_q == READ);
    assign mem_addr = 16'({page_q, idx_q});
    assign oam_data = data_q;

`ifdef OAM_DMA_DEBUG_EN
    logic [15:0] dbg_count_q;
    logic [7:0]  dbg_last_page_q;

    // Completed-transfer counter and last accepted page for the HEX displays.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_count_q     <= 16'd0;
            dbg_last_page_q <= 8'd0;
        end else begin
            if (done)   dbg_count_q     <= dbg_count_q + 16'd1;
            if (accept) dbg_last_page_q <= 8'(dma_page);
        end
    end

    assign dbg_count     = dbg_count_q;
    assign dbg_last_page = dbg_last_page_q;
`endif

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: a table of single-clk vectors for reset and
// start-up sequencing, then full transfers with a memory model and corner cases.
module tb_oam_dma_controller;

    logic        clk = 1'b0;
    logic        reset, cpu_ce, dma_wr;
    logic [7:0]  dma_page, mem_rdata;
    logic        cpu_halt, mem_rd, oam_wr, busy, done;
    logic [15:0] mem_addr;
    logic [7:0]  oam_data;
`ifdef OAM_DMA_DEBUG_EN
    logic [15:0] dbg_count;
    logic [7:0]  dbg_last_page;
`endif

    always #5 clk = ~clk;

    oam_dma_controller dut (
        .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .dma_wr(dma_wr),
        .dma_page(dma_page), .mem_rdata(mem_rdata), .cpu_halt(cpu_halt),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .oam_wr(oam_wr),
        .oam_data(oam_data), .busy(busy), .done(done)
`ifdef OAM_DMA_DEBUG_EN
        , .dbg_count(dbg_count), .dbg_last_page(dbg_last_page)
`endif
    );

    function automatic logic [7:0] memval(input logic [7:0] pg, input logic [7:0] lo);
        return pg ^ lo ^ 8'hA5;
    endfunction

    // Memory model: garbage when DMA is not reading.
    assign mem_rdata = mem_rd ? memval(mem_addr[15:8], mem_addr[7:0]) : 8'h3C;

    // Reference get/put parity.
    logic tb_odd = 1'b0;
    always @(posedge clk) tb_odd <= reset ? 1'b0 : (cpu_ce ? ~tb_odd : tb_odd);

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic rst, ce, wr;
        logic [7:0] pg;
        logic chk;
        logic busy, halt, rd, owr, dn;
        logic [15:0] addr;   // 16'hFFFF: not checked
        logic chkd;
        logic [7:0] odata;
    } vec_t;
    vec_t vq[$];

    function automatic void addv(input logic rst, ce, wr, input logic [7:0] pg, input logic chk,
                                 input logic b, h, r, o, d, input logic [15:0] a,
                                 input logic cd, input logic [7:0] od);
        vec_t v;
        v.rst = rst; v.ce = ce; v.wr = wr; v.pg = pg; v.chk = chk;
        v.busy = b; v.halt = h; v.rd = r; v.owr = o; v.dn = d;
        v.addr = a; v.chkd = cd; v.odata = od;
        vq.push_back(v);
    endfunction

    // Stepping state shared by the transfer sequences.
    int   phase = 0;
    bit   auto_ce = 0, ce_freeze = 0, reset_req = 0;
    bit   wr_pend = 0;
    int   wr_par = 0;        // 0/1: start on that parity, 2: any ce, 3: ce during a non-READ busy state
    logic [7:0] wr_page = 8'h00;
    logic [7:0] exp_page = 8'h00;
    int   halt_ce, wr_cnt, done_cnt;

    // One clk: drive inputs at negedge, sample #1 later, score writes/reads.
    task automatic step();
        @(negedge clk);
        reset  = reset_req;
        dma_wr = 1'b0;
        cpu_ce = auto_ce && !ce_freeze && (phase == 0);
        phase  = (phase + 1) % 4;
        if (wr_pend && cpu_ce &&
            ((wr_par == 2) || (wr_par == 3 && busy && !mem_rd) ||
             (wr_par < 2 && wr_par == int'(tb_odd)))) begin
            dma_wr   = 1'b1;
            dma_page = wr_page;
            wr_pend  = 1'b0;
        end
        #1;
        if (cpu_ce && cpu_halt) halt_ce++;
        if (cpu_ce && mem_rd) begin
            check("read_parity", tb_odd, 0);
            check("read_addr", mem_addr, {exp_page, wr_cnt[7:0]});
        end
        if (oam_wr) begin
            check("wr_on_ce", cpu_ce, 1);
            check("wr_data", oam_data, memval(exp_page, wr_cnt[7:0]));
            wr_cnt++;
        end
        if (done) done_cnt++;
    endtask

    task automatic run_xfer(input logic [7:0] pg, input int par, input int exp_halt,
                            input int inj_at, input int inj_par, input int frz_at);
        bit injd, frzd;
        logic [15:0] a;
        int w, n;
        halt_ce = 0; wr_cnt = 0; done_cnt = 0; exp_page = pg;
        injd = 0; frzd = 0;
        wr_page = pg; wr_par = par; wr_pend = 1;
        n = 0;
        while (n < 3000 && !(done_cnt > 0 && !busy)) begin
            if (!injd && inj_at >= 0 && wr_cnt == inj_at) begin
                injd = 1; wr_page = 8'h07; wr_par = inj_par; wr_pend = 1;
            end
            if (!frzd && frz_at >= 0 && wr_cnt == frz_at && mem_rd) begin
                frzd = 1; ce_freeze = 1; a = mem_addr; w = wr_cnt;
                repeat (20) begin
                    step();
                    check("frz_addr", mem_addr, a);
                    check("frz_rd", mem_rd, 1);
                end
                ce_freeze = 0;
                check("frz_nowr", wr_cnt, w);
            end
            step();
            n++;
        end
        wr_pend = 0;
        check("xfer_in_budget", int'(n < 3000), 1);
        check("halt_cycles", halt_ce, exp_halt);
        check("oam_wr_count", wr_cnt, 256);
        check("done_count", done_cnt, 1);
        check("busy_dropped", busy, 0);
        check("halt_dropped", cpu_halt, 0);
        repeat (40) step();
        check("no_restart_busy", busy, 0);
        check("no_extra_done", done_cnt, 1);
    endtask

    initial begin
        int n;
        reset = 1'b1; cpu_ce = 1'b0; dma_wr = 1'b0; dma_page = 8'h00;

        //   rst ce wr pg    chk bsy hlt rd owr dn addr      cd data
        addv(1, 0, 0, 8'h00, 0,  0, 0, 0, 0, 0, 16'hFFFF, 0, 8'h00);
        addv(0, 0, 0, 8'h00, 1,  0, 0, 0, 0, 0, 16'h0000, 1, 8'h00);
        addv(0, 0, 1, 8'h05, 1,  0, 0, 0, 0, 0, 16'h0000, 0, 8'h00);
        addv(0, 1, 0, 8'h00, 1,  0, 0, 0, 0, 0, 16'h0000, 0, 8'h00);
        addv(0, 1, 1, 8'h09, 1,  0, 0, 0, 0, 0, 16'hFFFF, 0, 8'h00);
        addv(0, 0, 0, 8'h00, 1,  1, 1, 0, 0, 0, 16'hFFFF, 0, 8'h00);
        addv(0, 1, 1, 8'h33, 1,  1, 1, 0, 0, 0, 16'hFFFF, 0, 8'h00);
        addv(0, 1, 0, 8'h00, 1,  1, 1, 0, 0, 0, 16'hFFFF, 0, 8'h00);
        addv(0, 0, 0, 8'h00, 1,  1, 1, 1, 0, 0, 16'h0900, 0, 8'h00);
        addv(0, 1, 0, 8'h00, 1,  1, 1, 1, 0, 0, 16'h0900, 0, 8'h00);
        addv(0, 0, 0, 8'h00, 1,  1, 1, 0, 0, 0, 16'h0900, 0, 8'h00);
        addv(0, 1, 0, 8'h00, 1,  1, 1, 0, 1, 0, 16'h0900, 1, 8'hAC);
        addv(0, 0, 0, 8'h00, 1,  1, 1, 1, 0, 0, 16'h0901, 0, 8'h00);
        addv(1, 1, 0, 8'h00, 1,  1, 1, 1, 0, 0, 16'h0901, 0, 8'h00);
        addv(0, 0, 0, 8'h00, 1,  0, 0, 0, 0, 0, 16'h0000, 1, 8'h00);
        addv(0, 1, 0, 8'h00, 1,  0, 0, 0, 0, 0, 16'h0000, 0, 8'h00);

        foreach (vq[i]) begin
            @(negedge clk);
            reset = vq[i].rst; cpu_ce = vq[i].ce; dma_wr = vq[i].wr; dma_page = vq[i].pg;
            #1;
            if (vq[i].chk) begin
                check($sformatf("v%0d_busy", i), busy, vq[i].busy);
                check($sformatf("v%0d_halt", i), cpu_halt, vq[i].halt);
                check($sformatf("v%0d_rd", i), mem_rd, vq[i].rd);
                check($sformatf("v%0d_oam_wr", i), oam_wr, vq[i].owr);
                check($sformatf("v%0d_done", i), done, vq[i].dn);
                if (vq[i].addr != 16'hFFFF) check($sformatf("v%0d_addr", i), mem_addr, vq[i].addr);
                if (vq[i].chkd) check($sformatf("v%0d_data", i), oam_data, vq[i].odata);
            end
        end

        auto_ce = 1;
        // HALT on an even cycle -> ALIGN inserted.
        run_xfer(8'h02, 1, 514, -1, 0, -1);
        // HALT on an odd cycle -> no ALIGN.
        run_xfer(8'h02, 0, 513, -1, 0, -1);
        // dma_wr page $07 at byte 100 is ignored.
        run_xfer(8'h03, 1, 514, 100, 2, -1);
`ifdef OAM_DMA_DEBUG_EN
        check("dbg_last_page_ignored", dbg_last_page, 8'h03);
`endif
        // dma_wr on the final WRITE cycle is ignored.
        run_xfer(8'h06, 1, 514, 255, 3, -1);
        // cpu_ce held low for 20 clks mid-READ.
        run_xfer(8'h08, 0, 513, -1, 0, 50);

        // Reset after 40 writes.
        halt_ce = 0; wr_cnt = 0; done_cnt = 0; exp_page = 8'h05;
        wr_page = 8'h05; wr_par = 2; wr_pend = 1;
        n = 0;
        while (wr_cnt < 40 && n < 3000) begin step(); n++; end
        check("reset_40_reached", wr_cnt, 40);
        reset_req = 1; step(); reset_req = 0; step();
        check("rst_busy", busy, 0);
        check("rst_halt", cpu_halt, 0);
        check("rst_rd", mem_rd, 0);
        repeat (300) step();
        check("rst_no_more_wr", wr_cnt, 40);
        check("rst_no_done", done_cnt, 0);
        run_xfer(8'h04, 1, 514, -1, 0, -1);

        // Three transfers from reset for the debug counters.
        reset_req = 1; step(); reset_req = 0;
        run_xfer(8'h01, 1, 514, -1, 0, -1);
        run_xfer(8'h02, 1, 514, -1, 0, -1);
        run_xfer(8'h03, 1, 514, -1, 0, -1);
`ifdef OAM_DMA_DEBUG_EN
        check("dbg_count", dbg_count, 3);
        check("dbg_last_page", dbg_last_page, 8'h03);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
